// File: rtl/param_commit_scheduler.sv
// Staging and frame-synchronous commit of the live waveform settings (amplitude,
// frequency, noise). Host writes and front-panel events share one staging write per cycle.
module param_commit_scheduler #(
  parameter int AMP_DEF     = 8,
  parameter int FREQ_DEF    = 8,
  parameter int NOISE_DEF   = 16,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int TO_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] ev_req,
  input  logic       host_req,
  input  logic [1:0] host_sel,
  input  logic [4:0] host_data,
  output logic       host_ack,
  output logic       host_err,
  input  logic       frame_sync,
  output logic [3:0] amp_factor,
  output logic [3:0] freq_factor,
  output logic [4:0] noise_amp_factor,
  output logic       cfg_update,
  output logic       pending
);

  localparam logic [3:0]      AMP_RST   = 4'(AMP_DEF);
  localparam logic [3:0]      FREQ_RST  = 4'(FREQ_DEF);
  localparam logic [4:0]      NOISE_RST = 5'(NOISE_DEF);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state_q;
  logic [TO_W-1:0] timer_q;

  logic [3:0] stg_amp_q,   stg_amp_d;
  logic [3:0] stg_freq_q,  stg_freq_d;
  logic [4:0] stg_noise_q, stg_noise_d;
  logic [5:0] ev_pend_q,   ev_pend_d;
  logic       host_ack_q,  host_ack_d;
  logic       host_err_q,  host_err_d;

  logic [3:0] live_amp_q;
  logic [3:0] live_freq_q;
  logic [4:0] live_noise_q;
  logic       cfg_update_q;

  logic       host_grant;
  logic [5:0] svc_mask;
  logic       timeout_hit;

  function automatic logic [3:0] clamp4(input logic [4:0] v);
    return (v > 5'd15) ? 4'd15 : v[3:0];
  endfunction

  function automatic logic [3:0] inc4(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] dec4(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

  function automatic logic [4:0] inc5(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  function automatic logic [4:0] dec5(input logic [4:0] v);
    return (v == 5'd0) ? v : v - 5'd1;
  endfunction

  // A request still high while its ack is showing is the tail of the write just served.
  assign host_grant = host_req & ~host_ack_q;

  always_comb begin
    stg_amp_d   = stg_amp_q;
    stg_freq_d  = stg_freq_q;
    stg_noise_d = stg_noise_q;
    svc_mask    = 6'b000000;
    host_ack_d  = 1'b0;
    host_err_d  = 1'b0;
    if (host_grant) begin
      host_ack_d = 1'b1;
      case (host_sel)
        2'd0:    stg_amp_d   = clamp4(host_data);
        2'd1:    stg_freq_d  = clamp4(host_data);
        2'd2:    stg_noise_d = host_data;
        default: host_err_d  = 1'b1;
      endcase
    end else if (ev_pend_q[0]) begin
      svc_mask  = 6'b000001;
      stg_amp_d = inc4(stg_amp_q);
    end else if (ev_pend_q[1]) begin
      svc_mask  = 6'b000010;
      stg_amp_d = dec4(stg_amp_q);
    end else if (ev_pend_q[2]) begin
      svc_mask   = 6'b000100;
      stg_freq_d = inc4(stg_freq_q);
    end else if (ev_pend_q[3]) begin
      svc_mask   = 6'b001000;
      stg_freq_d = dec4(stg_freq_q);
    end else if (ev_pend_q[4]) begin
      svc_mask    = 6'b010000;
      stg_noise_d = inc5(stg_noise_q);
    end else if (ev_pend_q[5]) begin
      svc_mask    = 6'b100000;
      stg_noise_d = dec5(stg_noise_q);
    end
    // A fresh pulse on the bit being serviced keeps it pending.
    ev_pend_d = (ev_pend_q & ~svc_mask) | ev_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_amp_q   <= AMP_RST;
      stg_freq_q  <= FREQ_RST;
      stg_noise_q <= NOISE_RST;
      ev_pend_q   <= 6'b000000;
      host_ack_q  <= 1'b0;
      host_err_q  <= 1'b0;
    end else begin
      stg_amp_q   <= stg_amp_d;
      stg_freq_q  <= stg_freq_d;
      stg_noise_q <= stg_noise_d;
      ev_pend_q   <= ev_pend_d;
      host_ack_q  <= host_ack_d;
      host_err_q  <= host_err_d;
    end
  end

  assign pending = (stg_amp_q   != live_amp_q)  |
                   (stg_freq_q  != live_freq_q) |
                   (stg_noise_q != live_noise_q);

  assign timeout_hit = (timer_q == TO_LAST);

  // Commit copies the registered staged values, so a write landing on the same edge waits a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      live_amp_q   <= AMP_RST;
      live_freq_q  <= FREQ_RST;
      live_noise_q <= NOISE_RST;
      cfg_update_q <= 1'b0;
    end else begin
      cfg_update_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pending) begin
            state_q <= ARMED;
            timer_q <= '0;
          end
        end
        ARMED: begin
          timer_q <= timer_q + TO_W'(1);
          if (!pending) begin
            state_q <= IDLE;
          end else if (frame_sync || timeout_hit) begin
            live_amp_q   <= stg_amp_q;
            live_freq_q  <= stg_freq_q;
            live_noise_q <= stg_noise_q;
            cfg_update_q <= 1'b1;
            state_q      <= COMMIT;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign host_ack         = host_ack_q;
  assign host_err         = host_err_q;
  assign amp_factor       = live_amp_q;
  assign freq_factor      = live_freq_q;
  assign noise_amp_factor = live_noise_q;
  assign cfg_update       = cfg_update_q;

endmodule

// File: tb/tb_param_commit_scheduler.sv
// Directed vector table plus hand sequences for timeout commit and asynchronous reset.
module tb_param_commit_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] ev_req;
  logic       host_req;
  logic [1:0] host_sel;
  logic [4:0] host_data;
  logic       host_ack;
  logic       host_err;
  logic       frame_sync;
  logic [3:0] amp_factor;
  logic [3:0] freq_factor;
  logic [4:0] noise_amp_factor;
  logic       cfg_update;
  logic       pending;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  param_commit_scheduler #(
    .AMP_DEF(8), .FREQ_DEF(8), .NOISE_DEF(16), .TIMEOUT_CYC(16), .TO_W(5)
  ) dut (
    .clk(clk), .rst(rst), .ev_req(ev_req), .host_req(host_req), .host_sel(host_sel),
    .host_data(host_data), .host_ack(host_ack), .host_err(host_err), .frame_sync(frame_sync),
    .amp_factor(amp_factor), .freq_factor(freq_factor), .noise_amp_factor(noise_amp_factor),
    .cfg_update(cfg_update), .pending(pending)
  );

  typedef struct {
    logic [5:0] ev;
    logic       hr;
    logic [1:0] hs;
    logic [4:0] hd;
    logic       fs;
    logic [3:0] amp;
    logic [3:0] freq;
    logic [4:0] noise;
    logic       upd;
    logic       pend;
    logic       ack;
    logic       err;
  } vec_t;

  localparam int NV = 46;
  vec_t vt [NV];

  function automatic vec_t mk(input logic [5:0] ev, input logic hr, input logic [1:0] hs,
                              input logic [4:0] hd, input logic fs, input logic [3:0] a,
                              input logic [3:0] f, input logic [4:0] n, input logic u,
                              input logic p, input logic k, input logic e);
    vec_t v;
    v.ev = ev; v.hr = hr; v.hs = hs; v.hd = hd; v.fs = fs;
    v.amp = a; v.freq = f; v.noise = n; v.upd = u; v.pend = p; v.ack = k; v.err = e;
    return v;
  endfunction

  task automatic step(input logic [5:0] ev, input logic hr, input logic [1:0] hs,
                      input logic [4:0] hd, input logic fs);
    @(negedge clk);
    ev_req = ev; host_req = hr; host_sel = hs; host_data = hd; frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] a, input logic [3:0] f,
                     input logic [4:0] n, input logic u, input logic p, input logic k,
                     input logic e);
    logic [15:0] got, exp;
    got = {amp_factor, freq_factor, noise_amp_factor, cfg_update, pending, host_ack, host_err};
    exp = {a, f, n, u, p, k, e};
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got amp=%0d freq=%0d noise=%0d upd=%b pend=%b ack=%b err=%b, expected amp=%0d freq=%0d noise=%0d upd=%b pend=%b ack=%b err=%b",
               name, amp_factor, freq_factor, noise_amp_factor, cfg_update, pending, host_ack,
               host_err, a, f, n, u, p, k, e);
    end
  endtask

  initial begin
    int  n;
    bit  seen;

    vt[0]  = mk(6'h01, 0, 0, 0,  0,  8, 8, 16, 0, 0, 0, 0);
    vt[1]  = mk(6'h00, 0, 0, 0,  0,  8, 8, 16, 0, 1, 0, 0);
    vt[2]  = mk(6'h00, 0, 0, 0,  0,  8, 8, 16, 0, 1, 0, 0);
    vt[3]  = mk(6'h00, 0, 0, 0,  0,  8, 8, 16, 0, 1, 0, 0);
    vt[4]  = mk(6'h00, 0, 0, 0,  0,  8, 8, 16, 0, 1, 0, 0);
    vt[5]  = mk(6'h01, 0, 0, 0,  0,  8, 8, 16, 0, 1, 0, 0);
    vt[6]  = mk(6'h00, 0, 0, 0,  0,  8, 8, 16, 0, 1, 0, 0);
    vt[7]  = mk(6'h00, 0, 0, 0,  0,  8, 8, 16, 0, 1, 0, 0);
    vt[8]  = mk(6'h00, 0, 0, 0,  0,  8, 8, 16, 0, 1, 0, 0);
    vt[9]  = mk(6'h00, 0, 0, 0,  0,  8, 8, 16, 0, 1, 0, 0);
    vt[10] = mk(6'h01, 0, 0, 0,  0,  8, 8, 16, 0, 1, 0, 0);
    vt[11] = mk(6'h00, 0, 0, 0,  0,  8, 8, 16, 0, 1, 0, 0);
    vt[12] = mk(6'h00, 0, 0, 0,  1, 11, 8, 16, 1, 0, 0, 0);
    vt[13] = mk(6'h00, 0, 0, 0,  0, 11, 8, 16, 0, 0, 0, 0);
    vt[14] = mk(6'h00, 0, 0, 0,  1, 11, 8, 16, 0, 0, 0, 0);
    vt[15] = mk(6'h10, 1, 2, 31, 0, 11, 8, 16, 0, 1, 1, 0);
    vt[16] = mk(6'h00, 0, 0, 0,  0, 11, 8, 16, 0, 1, 0, 0);
    vt[17] = mk(6'h00, 0, 0, 0,  0, 11, 8, 16, 0, 1, 0, 0);
    vt[18] = mk(6'h00, 0, 0, 0,  1, 11, 8, 31, 1, 0, 0, 0);
    vt[19] = mk(6'h00, 0, 0, 0,  0, 11, 8, 31, 0, 0, 0, 0);
    vt[20] = mk(6'h00, 1, 0, 20, 0, 11, 8, 31, 0, 1, 1, 0);
    vt[21] = mk(6'h00, 1, 0, 20, 0, 11, 8, 31, 0, 1, 0, 0);
    vt[22] = mk(6'h00, 0, 0, 0,  1, 15, 8, 31, 1, 0, 0, 0);
    vt[23] = mk(6'h00, 1, 3, 5,  0, 15, 8, 31, 0, 0, 1, 1);
    vt[24] = mk(6'h00, 0, 0, 0,  0, 15, 8, 31, 0, 0, 0, 0);
    vt[25] = mk(6'h01, 0, 0, 0,  0, 15, 8, 31, 0, 0, 0, 0);
    vt[26] = mk(6'h00, 0, 0, 0,  0, 15, 8, 31, 0, 0, 0, 0);
    vt[27] = mk(6'h00, 0, 0, 0,  0, 15, 8, 31, 0, 0, 0, 0);
    vt[28] = mk(6'h04, 0, 0, 0,  0, 15, 8, 31, 0, 0, 0, 0);
    vt[29] = mk(6'h08, 0, 0, 0,  0, 15, 8, 31, 0, 1, 0, 0);
    vt[30] = mk(6'h00, 0, 0, 0,  0, 15, 8, 31, 0, 0, 0, 0);
    vt[31] = mk(6'h00, 0, 0, 0,  0, 15, 8, 31, 0, 0, 0, 0);
    vt[32] = mk(6'h00, 0, 0, 0,  1, 15, 8, 31, 0, 0, 0, 0);
    vt[33] = mk(6'h20, 0, 0, 0,  0, 15, 8, 31, 0, 0, 0, 0);
    vt[34] = mk(6'h20, 0, 0, 0,  0, 15, 8, 31, 0, 1, 0, 0);
    vt[35] = mk(6'h00, 0, 0, 0,  0, 15, 8, 31, 0, 1, 0, 0);
    vt[36] = mk(6'h00, 0, 0, 0,  1, 15, 8, 29, 1, 0, 0, 0);
    vt[37] = mk(6'h00, 0, 0, 0,  0, 15, 8, 29, 0, 0, 0, 0);
    vt[38] = mk(6'h03, 0, 0, 0,  0, 15, 8, 29, 0, 0, 0, 0);
    vt[39] = mk(6'h02, 0, 0, 0,  0, 15, 8, 29, 0, 0, 0, 0);
    vt[40] = mk(6'h00, 0, 0, 0,  0, 15, 8, 29, 0, 1, 0, 0);
    vt[41] = mk(6'h00, 0, 0, 0,  0, 15, 8, 29, 0, 1, 0, 0);
    vt[42] = mk(6'h00, 0, 0, 0,  1, 14, 8, 29, 1, 0, 0, 0);
    vt[43] = mk(6'h00, 0, 0, 0,  0, 14, 8, 29, 0, 0, 0, 0);
    vt[44] = mk(6'h01, 0, 0, 0,  0, 14, 8, 29, 0, 0, 0, 0);
    vt[45] = mk(6'h00, 0, 0, 0,  0, 14, 8, 29, 0, 1, 0, 0);

    rst = 1'b1;
    ev_req = '0; host_req = 1'b0; host_sel = '0; host_data = '0; frame_sync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_defaults", 8, 8, 16, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step(vt[i].ev, vt[i].hr, vt[i].hs, vt[i].hd, vt[i].fs);
      chk($sformatf("vec%0d", i), vt[i].amp, vt[i].freq, vt[i].noise, vt[i].upd,
          vt[i].pend, vt[i].ack, vt[i].err);
    end

    // Staged amp=15 vs live 14: this edge enters ARMED, then no frame_sync ever arrives.
    step(6'h00, 0, 0, 0, 0);
    chk("armed_entry", 14, 8, 29, 0, 1, 0, 0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      step(6'h00, 0, 0, 0, 0);
      n++;
      if (cfg_update) seen = 1'b1;
    end
    applied++;
    if (!seen || n != 16) begin
      miscompares++;
      $display("FAIL timeout_latency: got seen=%0b cycles=%0d, expected seen=1 cycles=16", seen, n);
    end
    chk("timeout_commit", 15, 8, 29, 1, 0, 0, 0);
    step(6'h00, 0, 0, 0, 0);
    chk("timeout_after", 15, 8, 29, 0, 0, 0, 0);

    step(6'h04, 0, 0, 0, 0);
    step(6'h00, 0, 0, 0, 0);
    step(6'h00, 0, 0, 0, 0);
    step(6'h02, 0, 0, 0, 0);
    chk("armed_before_rst", 15, 8, 29, 0, 1, 0, 0);
    @(negedge clk);
    ev_req = '0;
    rst = 1'b1;
    #1;
    chk("reset_async", 8, 8, 16, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(6'h00, 0, 0, 0, 0);
      chk($sformatf("post_rst%0d", i), 8, 8, 16, 0, 0, 0, 0);
    end
    step(6'h00, 0, 0, 0, 1);
    chk("post_rst_fs", 8, 8, 16, 0, 0, 0, 0);
    step(6'h00, 0, 0, 0, 0);
    chk("post_rst_idle", 8, 8, 16, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
